adder_tree_scheduler: RTL
=========================

# adder_tree_scheduler

Time-multiplexed reduction controller for the adder-tree datapath. It accepts a frame of 8 unsigned operands serially over a valid/ready stream and reduces them pairwise, level by level, through one shared two-input adder. It returns the full-precision sum on a valid/ready output. It replaces the fully parallel 8-input adder tree wherever area matters more than throughput.

## Interface
Parameters:
- ADDER_WIDTH, 15, operand width in bits. Result width is ADDER_WIDTH+3.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  scheduler can accept an operand.
- in_data  input  ADDER_WIDTH  operand, unsigned.
- out_valid  output  1  out_sum valid.
- out_ready  input  1  consumer accepts out_sum.
- out_sum  output  ADDER_WIDTH+3  reduction result, unsigned.
- busy  output  1  high in REDUCE or DONE.

## Operation
- Storage: 8 slots, each ADDER_WIDTH+3 bits. Operands are zero-extended into the slots.
- Shared adder: one (ADDER_WIDTH+3)-bit adder, with at most one add per cycle. No overflow is possible: 8×(2^W−1) < 2^(W+3).
- FSM states: LOAD, REDUCE, DONE. Reset state is LOAD.
- LOAD:
  - in_ready=1.
  - On each edge with in_valid&in_ready, write in_data into slot[cnt] and increment the 3-bit cnt.
  - The beat with cnt=7 moves the FSM to REDUCE. cnt wraps to 0.
  - Idle cycles between beats are allowed and do not affect the result.
- REDUCE: in_ready=0. Adds are issued in fixed order, one per cycle:
  - L1: slot0=s0+s1, slot1=s2+s3, slot2=s4+s5, slot3=s6+s7.
  - L2: slot0=s0+s1, slot1=s2+s3.
  - L3: slot0=s0+s1.
  - After the last add, go to DONE.
- DONE:
  - out_valid=1 and out_sum=slot0.
  - Both are held stable while out_ready=0.
  - On out_valid&out_ready, go to LOAD and clear cnt.
  - in_ready=0 throughout DONE, so there is no operand acceptance in the same cycle as the output handshake.
- Reset values: in_ready=1, out_valid=0, out_sum=0, busy=0, cnt=0, slots=0, state=LOAD.
- Reset mid-frame (LOAD, REDUCE or DONE): the frame is discarded immediately. Outputs take their reset values asynchronously. The next frame after release is computed correctly.

## Timing
- Input throughput: one operand per cycle maximum.
- Latency: the 8th operand is accepted at edge E0. The reduce writes occur at edges E1..E7. out_valid is high from just after E7, i.e. 7 cycles after the last-beat accept.
- With out_ready held high: out_valid is high for exactly one cycle, and in_ready returns high the cycle after the output handshake.
- Minimum frame period: 8 load + 7 reduce + 1 done = 16 cycles.
- All outputs are registered or decoded directly from state. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- ADDER_TREE_2LEVEL_EN (defined):
  - The scheduler still loads all 8 beats; operands 4..7 are accepted and discarded.
  - REDUCE performs only: slot0=s0+s1, slot1=s2+s3, then slot0=s0+s1 (3 cycles).
  - out_sum = sum of operands 0..3, zero-extended to ADDER_WIDTH+3.
  - Latency is 3 cycles after the last-beat accept.
- ADDER_TREE_2LEVEL_EN (undefined): full 3-level, 7-add reduction of all 8 operands as above.

## Test plan
- Reset: hold rst_n=0, then release. Required: in_ready=1, out_valid=0, busy=0, out_sum=0. Assert rst_n low mid-cycle and check that outputs clear without a clock edge.
- Basic frame, ADDER_WIDTH=15: operands 1,2,…,8 on consecutive cycles. Required: out_sum=36, with out_valid rising exactly 7 cycles after the 8th accept.
- Max values: 8×0x7FFF. Required: out_sum=0x3FFF8 (18 bits), with no truncation.
- Backpressure and gaps:
  - Insert random idle cycles between beats, then hold out_ready=0 for 5 cycles. Required: the result is unchanged, out_valid and out_sum are stable, and in_ready=0 while out_ready is low.
  - Release out_ready. Required: in_ready=1 on the next cycle.
  - Send a second frame of 8×1. Required: out_sum=8.
- Reset mid-REDUCE: assert rst_n at the 3rd reduce cycle. Required: out_valid never asserts for that frame. A following frame 10,20,…,80 yields 360.
- ADDER_TREE_2LEVEL_EN defined: operands 1..8. Required: out_sum=10, with out_valid 3 cycles after the 8th accept.

Source files
------------

// File: rtl/adder_tree_scheduler.sv
// Serial 8-operand reduction through one shared adder (LOAD -> REDUCE -> DONE).
// Define ADDER_TREE_2LEVEL_EN to reduce only operands 0..3 in three adds.
module adder_tree_scheduler #(
    parameter int ADDER_WIDTH = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDER_WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDER_WIDTH+2:0] out_sum,
    output logic                   busy
);

    localparam int SW = ADDER_WIDTH + 3;

`ifdef ADDER_TREE_2LEVEL_EN
    localparam logic [2:0] LAST_STEP = 3'd2;
`else
    localparam logic [2:0] LAST_STEP = 3'd6;
`endif

    typedef enum logic [1:0] {
        LOAD,
        REDUCE,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [2:0]      step_q, step_d;
    logic [SW-1:0]   slot_q [8];
    logic [SW-1:0]   slot_d [8];
    logic [2:0]      src;
    logic [2:0]      dst;
    logic [SW-1:0]   sum;

    // Fixed add schedule: dst <= slot[src] + slot[src+1], src always even
    always_comb begin
        src = 3'd0;
        dst = 3'd0;
        unique case (step_q)
            3'd1: begin src = 3'd2; dst = 3'd1; end
`ifndef ADDER_TREE_2LEVEL_EN
            3'd2: begin src = 3'd4; dst = 3'd2; end
            3'd3: begin src = 3'd6; dst = 3'd3; end
            3'd5: begin src = 3'd2; dst = 3'd1; end
`endif
            default: begin src = 3'd0; dst = 3'd0; end
        endcase
    end

    assign sum = slot_q[src] + slot_q[src | 3'd1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        slot_d  = slot_q;
        unique case (state_q)
            LOAD: begin
                if (in_valid) begin
`ifdef ADDER_TREE_2LEVEL_EN
                    if (!cnt_q[2])
                        slot_d[cnt_q] = {3'b000, in_data};
`else
                    slot_d[cnt_q] = {3'b000, in_data};
`endif
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = REDUCE;
                        step_d  = 3'd0;
                    end
                end
            end
            REDUCE: begin
                slot_d[dst] = sum;
                step_d      = step_q + 3'd1;
                if (step_q == LAST_STEP)
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = LOAD;
                    cnt_d   = 3'd0;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= 3'd0;
            step_q  <= 3'd0;
            for (int i = 0; i < 8; i++)
                slot_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            for (int i = 0; i < 8; i++)
                slot_q[i] <= slot_d[i];
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != LOAD);
    assign out_sum   = (state_q == DONE) ? slot_q[0] : '0;

endmodule
